// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and state encoding for the interrupt pending controller.
package irq_pending_ctrl_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic [N-1:0] ENABLE_RESET = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_pending_ctrl_sync.sv
// Per-bit multi-stage synchroniser followed by a one-cycle rising-edge pulse.
module sync_edge_detect #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_rise
);

    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [N-1:0]                  r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures request edges as sticky pending bits, masks them with an enable
// register and runs the req/ack/eoi handshake feeding the priority encoder.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic             en_wr,
    input  logic [N-1:0]     en_data,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             eoi,
    output logic [N-1:0]     pend_out,
    output logic             en_out,
    output logic             irq,
    output logic             busy
);

    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_next;
    logic [N-1:0] w_en_next;
    logic [N-1:0] w_pend_out_next;
    logic [N-1:0] r_pend;
    logic [N-1:0] r_en;
    state_t       r_state;
    state_t       w_state_next;

    sync_edge_detect #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (req_in),
        .o_rise  (w_rise)
    );

    always_comb begin
        w_clr = '0;
        if (r_state == REQ && ack) begin
            w_clr[ack_idx] = 1'b1;
        end
    end

    // Set wins over clear so an event arriving with its own ack is kept.
    assign w_pend_next     = (r_pend & ~w_clr) | w_rise;
    assign w_en_next       = en_wr ? en_data : r_en;
    assign w_pend_out_next = w_pend_next & w_en_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_en    <= ENABLE_RESET;
            r_state <= IDLE;
        end else begin
            r_pend  <= w_pend_next;
            r_en    <= w_en_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        irq          = 1'b0;
        en_out       = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (pend_out != '0) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                irq    = 1'b1;
                en_out = 1'b1;
                if (ack) begin
                    w_state_next = SERVICE;
                end else if (pend_out == '0) begin
                    w_state_next = IDLE;
                end
            end
            SERVICE: begin
                busy = 1'b1;
                // Decide on the post-update view so events landing now are not missed.
                if (eoi) begin
                    w_state_next = (w_pend_out_next != '0) ? REQ : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign pend_out = r_pend & r_en;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench: cycle-by-cycle vector table plus hand sequences for corner cases.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       en_wr;
    logic [7:0] en_data;
    logic       ack;
    logic [2:0] ack_idx;
    logic       eoi;
    logic [7:0] pend_out;
    logic       en_out;
    logic       irq;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .en_wr    (en_wr),
        .en_data  (en_data),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .eoi      (eoi),
        .pend_out (pend_out),
        .en_out   (en_out),
        .irq      (irq),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       en_wr;
        logic [7:0] en_data;
        logic       ack;
        logic [2:0] ack_idx;
        logic       eoi;
        logic [7:0] exp_pend;
        logic       exp_irq;
        logic       exp_busy;
    } vec_t;

    localparam int NV = 39;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] r, input logic w, input logic [7:0] d,
                                input logic a, input logic [2:0] ai, input logic e,
                                input logic [7:0] p, input logic ir, input logic b);
        vec_t v;
        v.req = r; v.en_wr = w; v.en_data = d; v.ack = a; v.ack_idx = ai; v.eoi = e;
        v.exp_pend = p; v.exp_irq = ir; v.exp_busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_out(input string tag, input logic [7:0] p, input logic ir, input logic b);
        chk({tag, "_pend"}, pend_out, p);
        chk({tag, "_irq"}, {7'd0, irq}, {7'd0, ir});
        chk({tag, "_en_out"}, {7'd0, en_out}, {7'd0, ir});
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
    endtask

    initial begin
        // Each row: inputs driven at negedge, outputs expected after the next posedge.
        //            req    wr  data   ack idx eoi   pend   irq busy
        vecs[0]  = mk(8'h10, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(8'h10, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(8'h10, 0, 8'h00, 0, 0, 0, 8'h10, 0, 0);
        vecs[3]  = mk(8'h10, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0);
        vecs[4]  = mk(8'h10, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0);
        vecs[5]  = mk(8'h10, 0, 8'h00, 1, 4, 0, 8'h00, 0, 1);
        vecs[6]  = mk(8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        vecs[7]  = mk(8'h05, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[8]  = mk(8'h05, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[9]  = mk(8'h05, 0, 8'h00, 0, 0, 0, 8'h05, 0, 0);
        vecs[10] = mk(8'h05, 0, 8'h00, 0, 0, 0, 8'h05, 1, 0);
        vecs[11] = mk(8'h05, 0, 8'h00, 1, 2, 0, 8'h01, 0, 1);
        vecs[12] = mk(8'h05, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
        vecs[13] = mk(8'h05, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        vecs[14] = mk(8'h05, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        vecs[15] = mk(8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[16] = mk(8'h80, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[17] = mk(8'h80, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[18] = mk(8'h80, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[19] = mk(8'h80, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[20] = mk(8'h80, 1, 8'h80, 0, 0, 0, 8'h80, 0, 0);
        vecs[21] = mk(8'h80, 0, 8'h00, 0, 0, 0, 8'h80, 1, 0);
        vecs[22] = mk(8'h80, 0, 8'h00, 1, 7, 0, 8'h00, 0, 1);
        vecs[23] = mk(8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        vecs[24] = mk(8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 0);
        vecs[25] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[26] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[27] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 0, 0);
        vecs[28] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0);
        vecs[29] = mk(8'h02, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        vecs[30] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vecs[31] = mk(8'h02, 1, 8'hFF, 0, 0, 0, 8'h02, 0, 0);
        vecs[32] = mk(8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0);
        vecs[33] = mk(8'h02, 0, 8'h00, 1, 5, 0, 8'h02, 0, 1);
        vecs[34] = mk(8'h02, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
        vecs[35] = mk(8'h02, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
        vecs[36] = mk(8'h02, 0, 8'h00, 1, 1, 1, 8'h00, 0, 1);
        vecs[37] = mk(8'h02, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        vecs[38] = mk(8'h00, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);

        rst = 1'b1; req_in = '0; en_wr = 1'b0; en_data = '0;
        ack = 1'b0; ack_idx = '0; eoi = 1'b0;
        #1;
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req_in  = vecs[i].req;
            en_wr   = vecs[i].en_wr;
            en_data = vecs[i].en_data;
            ack     = vecs[i].ack;
            ack_idx = vecs[i].ack_idx;
            eoi     = vecs[i].eoi;
            tick();
            chk_out($sformatf("v%0d", i), vecs[i].exp_pend, vecs[i].exp_irq, vecs[i].exp_busy);
        end
        en_wr = 1'b0; ack = 1'b0; eoi = 1'b0;

        // New bit-3 edge lands in the same cycle as the ack that clears bit 3.
        req_in = 8'h08;
        ticks(4);
        chk_out("sc_req", 8'h08, 1'b1, 1'b0);
        req_in = 8'h00;
        ticks(4);
        req_in = 8'h08;
        ticks(2);
        ack = 1'b1; ack_idx = 3'd3;
        tick();
        ack = 1'b0;
        chk_out("sc_keep", 8'h08, 1'b0, 1'b1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_out("sc_eoi", 8'h08, 1'b1, 1'b0);
        ack = 1'b1; ack_idx = 3'd3;
        tick();
        ack = 1'b0; eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_out("sc_idle", 8'h00, 1'b0, 1'b0);

        // Hidden pending bit, ack while IDLE must not clear it.
        en_wr = 1'b1; en_data = 8'h00;
        tick();
        en_wr = 1'b0;
        req_in = 8'h48;
        ticks(3);
        chk_out("hid", 8'h00, 1'b0, 1'b0);
        ack = 1'b1; ack_idx = 3'd6;
        tick();
        ack = 1'b0;
        chk_out("idle_ack", 8'h00, 1'b0, 1'b0);
        en_wr = 1'b1; en_data = 8'hFF;
        tick();
        en_wr = 1'b0;
        chk_out("reen", 8'h40, 1'b0, 1'b0);
        tick();
        chk_out("reen_req", 8'h40, 1'b1, 1'b0);
        ack = 1'b1; ack_idx = 3'd0;
        tick();
        ack = 1'b0;
        chk_out("svc", 8'h40, 1'b0, 1'b1);

        // Asynchronous reset in SERVICE, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_out("arst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ticks(2);
        chk_out("post_rst2", 8'h00, 1'b0, 1'b0);
        tick();
        chk_out("post_rst3", 8'h48, 1'b0, 1'b0);
        tick();
        chk_out("post_rst4", 8'h48, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
